// File: rtl/uart_tx_buf.sv
// uart_tx_buf: buffered UART transmitter (8N1, optional even parity).
// Bytes offered on a valid/ready handshake are queued in a small circular
// FIFO. The FSM serialises them LSB-first onto a registered, idle-high line.
//
// Ports:
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   data_i     byte to send (captured only on an accepted write)
//   valid_i    data_i is valid
//   ready_o    FIFO has room; a write happens on valid_i && ready_o
//   uart_tx_o  serial line, idle high, registered
//   busy_o     frame in progress or FIFO non-empty
//   level_o    FIFO occupancy
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11-bit frames).
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (line low)
// DATA   | data bits, LSB first
// PARITY | even parity bit (UART_TX_PARITY_EN only)
// STOP   | stop bit (line high); chains into START if data is queued
module uart_tx_buf #(
  parameter int CLK_DIV    = 1042,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          uart_tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);
  localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    shift, shift_nx;
  logic          tx, tx_nx;
  logic          load, pop, push;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [7:0]    head;

  assign head      = mem[rd_ptr];
  assign ready_o   = (level != FULL);
  assign push      = valid_i && ready_o;
  assign level_o   = level;
  assign uart_tx_o = tx;
  assign busy_o    = (state != IDLE) || (level != '0);

  // FIFO storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)    par <= 1'b0;
    else if (pop) par <= ^head;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_nx;
      shift   <= shift_nx;
      tx      <= tx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_idx;
    shift_nx = shift;
    tx_nx    = tx;
    load     = 1'b0;
    pop      = 1'b0;

    case (state)
      IDLE: begin
        tx_nx = 1'b1;
        load  = (level != '0);
      end
      START: begin
        if (cnt == '0) begin
          state_nx = DATA;
          bit_nx   = 3'd0;
          cnt_nx   = CNT_LOAD;
          tx_nx    = shift[0];
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_nx = CNT_LOAD;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nx = PARITY;
            tx_nx    = par;
`else
            state_nx = STOP;
            tx_nx    = 1'b1;
`endif
          end else begin
            bit_nx   = bit_idx + 3'd1;
            shift_nx = shift >> 1;
            tx_nx    = shift[1];
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt == '0) begin
          state_nx = STOP;
          cnt_nx   = CNT_LOAD;
          tx_nx    = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == '0) begin
          state_nx = IDLE;
          tx_nx    = 1'b1;
          // Queued data chains directly into the next start bit.
          load     = (level != '0);
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
      end
    endcase

    if (load) begin
      pop      = 1'b1;
      shift_nx = head;
      cnt_nx   = CNT_LOAD;
      tx_nx    = 1'b0;
      state_nx = START;
    end
  end

endmodule
